// File: rtl/rxf_out_capture.sv
// rxf_out_capture: RX-filter output capture buffer with start offset, capture length and FIFO read port
module rxf_out_capture #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int OFS_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iClear,
    input  logic                iStart,
    input  logic                iSampleEn,
    input  logic [DATA_W-1:0]   iDataI,
    input  logic [DATA_W-1:0]   iDataQ,
    input  logic [OFS_W-1:0]    iStartOffset,
    input  logic [OFS_W-1:0]    iCapLen,
    input  logic                iRdEn,
    output logic [2*DATA_W-1:0] oRdData,
    output logic                oRdValid,
    output logic [ADDR_W:0]     oLevel,
    output logic                oEmpty,
    output logic                oFull,
    output logic                oOverflow,
    output logic                oBusy,
    output logic                oDone
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT_OFS, CAPTURE, DONE} state_t;

    state_t              state, stateNext;
    logic                rStartD;
    logic [OFS_W-1:0]    rOfs, rLen, rDiscCnt, rCapCnt, discNext, capNext;
    logic [ADDR_W-1:0]   rWrPtr, rRdPtr;
    logic [ADDR_W:0]     rLevel;
    logic [2*DATA_W-1:0] mem [DEPTH];
    logic                start, capStrobe, push, pop, drop;

    assign start     = iStart & ~rStartD;
    assign oLevel    = rLevel;
    assign oEmpty    = rLevel == '0;
    assign oFull     = rLevel == (ADDR_W+1)'(DEPTH);
    assign oBusy     = (state == WAIT_OFS) || (state == CAPTURE);
    assign oDone     = state == DONE;
    assign capStrobe = iSampleEn & (state == CAPTURE);
    assign pop       = iRdEn & ~oEmpty & ~iClear;
    assign push      = capStrobe & (~oFull | pop) & ~iClear;
    assign drop      = capStrobe & oFull & ~pop & ~iClear;
    assign discNext  = (rDiscCnt == '1) ? rDiscCnt : rDiscCnt + 1'b1;
    assign capNext   = (rCapCnt == '1) ? rCapCnt : rCapCnt + 1'b1;

    // Next state: offset 0 skips the discard phase; clear always wins
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (start) stateNext = (iStartOffset == '0) ? CAPTURE : WAIT_OFS;
            WAIT_OFS: if (iSampleEn && discNext == rOfs) stateNext = CAPTURE;
            CAPTURE:  if (iSampleEn && rLen != '0 && capNext == rLen) stateNext = DONE;
            default:  stateNext = state;
        endcase
        if (iClear) stateNext = IDLE;
    end

    // State, start edge detect, latched parameters and strobe counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rStartD  <= 1'b0;
            rOfs     <= '0;
            rLen     <= '0;
            rDiscCnt <= '0;
            rCapCnt  <= '0;
        end else begin
            state   <= stateNext;
            rStartD <= iStart;
            if (iClear) begin
                rDiscCnt <= '0;
                rCapCnt  <= '0;
            end else if (state == IDLE && start) begin
                rOfs     <= iStartOffset;
                rLen     <= iCapLen;
                rDiscCnt <= '0;
                rCapCnt  <= '0;
            end else begin
                if (state == WAIT_OFS && iSampleEn) rDiscCnt <= discNext;
                if (capStrobe) rCapCnt <= capNext;
            end
        end
    end

    // FIFO pointers, occupancy, sticky overflow and registered read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rWrPtr    <= '0;
            rRdPtr    <= '0;
            rLevel    <= '0;
            oOverflow <= 1'b0;
            oRdValid  <= 1'b0;
            oRdData   <= '0;
        end else if (iClear) begin
            rWrPtr    <= '0;
            rRdPtr    <= '0;
            rLevel    <= '0;
            oOverflow <= 1'b0;
            oRdValid  <= 1'b0;
            oRdData   <= '0;
        end else begin
            if (push) rWrPtr <= rWrPtr + 1'b1;
            if (pop) begin
                rRdPtr  <= rRdPtr + 1'b1;
                oRdData <= mem[rRdPtr];
            end
            if (drop) oOverflow <= 1'b1;
            oRdValid <= pop;
            rLevel   <= rLevel + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        end
    end

    // Sample storage; contents need no reset
    always_ff @(posedge clk) begin
        if (push) mem[rWrPtr] <= {iDataI, iDataQ};
    end
endmodule

// File: tb/tb_rxf_out_capture.sv
// tb_rxf_out_capture: vector table plus corner sequences with a read-data scoreboard
module tb_rxf_out_capture;
    logic clk = 0, reset = 1, iClear = 0, iStart = 0, iSampleEn = 0, rdA = 0, rdB = 0;
    logic [7:0] iDataI = 0, iDataQ = 0;
    logic [15:0] iStartOffset = 0, iCapLen = 0;
    logic [15:0] rdDataA, rdDataB;
    logic rdValidA, emptyA, fullA, ovfA, busyA, doneA;
    logic rdValidB, emptyB, fullB, ovfB, busyB, doneB;
    logic [8:0] levelA;
    logic [2:0] levelB;
    int checks = 0, errors = 0;
    logic [15:0] qA[$], qB[$];

    typedef struct {
        int ofs;
        int len;
        int n;
        int level;
        bit done;
        bit busy;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    rxf_out_capture #(.DATA_W(8), .ADDR_W(8), .OFS_W(16)) dutA (
        .clk(clk), .reset(reset), .iClear(iClear), .iStart(iStart), .iSampleEn(iSampleEn),
        .iDataI(iDataI), .iDataQ(iDataQ), .iStartOffset(iStartOffset), .iCapLen(iCapLen),
        .iRdEn(rdA), .oRdData(rdDataA), .oRdValid(rdValidA), .oLevel(levelA), .oEmpty(emptyA),
        .oFull(fullA), .oOverflow(ovfA), .oBusy(busyA), .oDone(doneA));

    rxf_out_capture #(.DATA_W(8), .ADDR_W(2), .OFS_W(16)) dutB (
        .clk(clk), .reset(reset), .iClear(iClear), .iStart(iStart), .iSampleEn(iSampleEn),
        .iDataI(iDataI), .iDataQ(iDataQ), .iStartOffset(iStartOffset), .iCapLen(iCapLen),
        .iRdEn(rdB), .oRdData(rdDataB), .oRdValid(rdValidB), .oLevel(levelB), .oEmpty(emptyB),
        .oFull(fullB), .oOverflow(ovfB), .oBusy(busyB), .oDone(doneB));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    // Read-data scoreboards: every valid read must match the oldest expected sample
    always @(negedge clk) begin
        if (rdValidA) begin
            if (qA.size() == 0) chk("rdA_unexpected", 1, 0);
            else chk("rdA_data", rdDataA, qA.pop_front());
        end
        if (rdValidB) begin
            if (qB.size() == 0) chk("rdB_unexpected", 1, 0);
            else chk("rdB_data", rdDataB, qB.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int idx, input logic rd);
        logic [7:0] b;
        b = idx[7:0];
        iSampleEn = 1;
        iDataI = b;
        iDataQ = ~b;
        rdB = rd;
        tick();
        iSampleEn = 0;
        rdB = 0;
    endtask

    task automatic expect_s(input int idx, input bit toB);
        logic [7:0] b;
        b = idx[7:0];
        if (toB) qB.push_back({b, ~b});
        else qA.push_back({b, ~b});
    endtask

    task automatic doClear();
        iClear = 1;
        tick();
        iClear = 0;
    endtask

    task automatic doStart(input int ofs, input int len);
        iStartOffset = ofs[15:0];
        iCapLen = len[15:0];
        iStart = 1;
        tick();
        iStart = 0;
    endtask

    task automatic drainA(input int n);
        rdA = 1;
        repeat (n) tick();
        rdA = 0;
        tick();
        tick();
        chk("drainA_left", qA.size(), 0);
        chk("drainA_empty", emptyA, 1);
    endtask

    task automatic drainB(input int n);
        rdB = 1;
        repeat (n) tick();
        rdB = 0;
        tick();
        tick();
        chk("drainB_left", qB.size(), 0);
        chk("drainB_empty", emptyB, 1);
    endtask

    initial begin
        bit fin;
        vecs[0] = '{ofs: 12, len: 5,  n: 20, level: 5, done: 1, busy: 0};
        vecs[1] = '{ofs: 0,  len: 1,  n: 3,  level: 1, done: 1, busy: 0};
        vecs[2] = '{ofs: 3,  len: 0,  n: 10, level: 7, done: 0, busy: 1};
        vecs[3] = '{ofs: 5,  len: 10, n: 8,  level: 3, done: 0, busy: 1};
        vecs[4] = '{ofs: 1,  len: 2,  n: 2,  level: 1, done: 0, busy: 1};

        #1;
        chk("rst_empty", emptyA, 1);
        chk("rst_full", fullA, 0);
        chk("rst_level", levelA, 0);
        chk("rst_ovf", ovfA, 0);
        chk("rst_busy", busyA, 0);
        chk("rst_done", doneA, 0);
        chk("rst_rdvalid", rdValidA, 0);
        chk("rst_rddata", rdDataA, 0);
        @(negedge clk);
        reset = 0;
        tick();

        foreach (vecs[k]) begin
            doClear();
            chk("clr_busy", busyA, 0);
            chk("clr_level", levelA, 0);
            doStart(vecs[k].ofs, vecs[k].len);
            chk("start_busy", busyA, 1);
            for (int i = 1; i <= vecs[k].n; i++) begin
                fin = vecs[k].len != 0 && i >= vecs[k].ofs + vecs[k].len;
                if (i > vecs[k].ofs && (vecs[k].len == 0 || i <= vecs[k].ofs + vecs[k].len))
                    expect_s(i, 0);
                strobe(i, 0);
                chk("vec_level", levelA, qA.size());
                chk("vec_done", doneA, fin);
                chk("vec_busy", busyA, !fin);
                tick();
                tick();
                tick();
            end
            chk("vec_level_end", levelA, vecs[k].level);
            chk("vec_done_end", doneA, vecs[k].done);
            chk("vec_busy_end", busyA, vecs[k].busy);
            chk("vec_ovf", ovfA, 0);
            drainA(vecs[k].level);
        end

        doClear();
        doStart(0, 0);
        for (int i = 1; i <= 4; i++) begin
            expect_s(i, 1);
            strobe(i, 0);
        end
        chk("b_full", fullB, 1);
        chk("b_ovf_at_full", ovfB, 0);
        chk("b_level_full", levelB, 4);
        expect_s(5, 1);
        strobe(5, 1);
        chk("b_rw_level", levelB, 4);
        chk("b_rw_ovf", ovfB, 0);
        chk("b_rw_full", fullB, 1);
        strobe(6, 0);
        chk("b_ovf_set", ovfB, 1);
        chk("b_ovf_level", levelB, 4);
        drainB(4);
        rdB = 1;
        tick();
        rdB = 0;
        chk("b_rd_empty_valid", rdValidB, 0);
        chk("b_rd_empty_level", levelB, 0);
        chk("b_ovf_sticky", ovfB, 1);
        doClear();
        chk("b_clr_ovf", ovfB, 0);

        doClear();
        doStart(0, 3);
        expect_s(1, 0);
        strobe(1, 0);
        iStart = 1;
        tick();
        iStart = 0;
        expect_s(2, 0);
        strobe(2, 0);
        chk("retrig_level", levelA, 2);
        chk("retrig_busy", busyA, 1);
        expect_s(3, 0);
        strobe(3, 0);
        chk("retrig_done", doneA, 1);
        chk("retrig_level3", levelA, 3);
        strobe(4, 0);
        chk("done_nowrite", levelA, 3);
        drainA(3);

        doClear();
        doStart(0, 0);
        strobe(1, 0);
        chk("pre_clr_level", levelA, 1);
        iClear = 1;
        iSampleEn = 1;
        tick();
        iClear = 0;
        iSampleEn = 0;
        chk("clr_strobe_level", levelA, 0);
        chk("clr_strobe_empty", emptyA, 1);
        chk("clr_strobe_busy", busyA, 0);
        doStart(0, 0);
        chk("rearm_busy", busyA, 1);
        expect_s(9, 0);
        strobe(9, 0);
        chk("rearm_level", levelA, 1);
        drainA(1);

        doClear();
        doStart(0, 0);
        strobe(1, 0);
        strobe(2, 0);
        chk("pre_rst_level", levelA, 2);
        #2;
        reset = 1;
        iStart = 1;
        #1;
        chk("arst_empty", emptyA, 1);
        chk("arst_busy", busyA, 0);
        chk("arst_level", levelA, 0);
        chk("arst_done", doneA, 0);
        chk("arst_ovf", ovfB, 0);
        qA.delete();
        qB.delete();
        @(negedge clk);
        reset = 0;
        tick();
        chk("arst_start_busy", busyA, 1);
        iStart = 0;
        expect_s(7, 0);
        strobe(7, 0);
        chk("arst_cap_level", levelA, 1);
        drainA(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
